// File: rtl/sdram_read_arbiter_if.sv
// Bus bundle between the read requesters, the arbiter and the SDRAM burst-read port.
//   req_*       : per-requester burst handshake (request/address in, ack/valid/complete/data out)
//   mem_*       : single shared SDRAM burst-read master port
//   grant       : one-hot current owner of the memory port
//   burst_error : sticky protocol-error flag
// Modport slave is the arbiter's view; modport master is the surrounding system's view.
interface sdram_read_arbiter_if #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = 26
) ();
   logic [NUM_REQ-1:0]        req_request;
   logic [NUM_REQ*ADDR_W-1:0] req_address;
   logic [NUM_REQ-1:0]        req_ack;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_complete;
   logic [31:0]               req_data;
   logic [ADDR_W-1:0]         mem_address;
   logic                      mem_request;
   logic [31:0]               mem_data;
   logic                      mem_valid;
   logic                      mem_ack;
   logic                      mem_complete;
   logic [NUM_REQ-1:0]        grant;
   logic                      burst_error;

   modport slave (
      input  req_request, req_address, mem_data, mem_valid, mem_ack, mem_complete,
      output req_ack, req_valid, req_complete, req_data, mem_address, mem_request,
             grant, burst_error
   );

   modport master (
      output req_request, req_address, mem_data, mem_valid, mem_ack, mem_complete,
      input  req_ack, req_valid, req_complete, req_data, mem_address, mem_request,
             grant, burst_error
   );
endinterface

// File: rtl/sdram_read_arbiter.sv
// Round-robin arbiter sharing one SDRAM burst-read port among NUM_REQ read-only requesters.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : requester handshakes, memory port, grant and burst_error (see sdram_read_arbiter_if)
// Memory responses are steered combinationally to the granted requester; mem_request,
// mem_address, grant and burst_error are registered.
module sdram_read_arbiter #(
   parameter int unsigned NUM_REQ   = 3,
   parameter int unsigned ADDR_W    = 26,
   parameter int unsigned BURST_LEN = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   sdram_read_arbiter_if.slave  bus
);
   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned SEL_W = $clog2(NUM_REQ * ADDR_W);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LEN_CNT  = CNT_W'(BURST_LEN);
   localparam logic [CNT_W:0]   LEN_CNT1 = (CNT_W+1)'(BURST_LEN);

   typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

   state_t             state, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               mreq_q, mreq_d;
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
   logic [IDX_W-1:0]   winner, winner_d;
   logic [CNT_W-1:0]   count, count_d;
   logic               err_q, err_d;

   logic               found;
   logic [IDX_W-1:0]   pick;
   logic [ADDR_W-1:0]  pick_addr;
   logic [SEL_W-1:0]   base;
   logic [CNT_W:0]     seen;
   logic [IDX_W-1:0]   rr_next;
   int                 idx;

   // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      found     = 1'b0;
      pick      = '0;
      pick_addr = '0;
      base      = '0;
      idx       = 0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         idx = (int'(rr_ptr) + i) % int'(NUM_REQ);
         if (!found && bus.req_request[IDX_W'(idx)]) begin
            found     = 1'b1;
            pick      = IDX_W'(idx);
            base      = SEL_W'(idx) * SEL_W'(ADDR_W);
            pick_addr = bus.req_address[base +: ADDR_W];
         end
      end
   end

   // Pointer moves one past the requester that just finished
   assign rr_next = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);

   // Words counted including a valid that lands in the same cycle as complete
   assign seen = {1'b0, count} + (CNT_W+1)'(bus.mem_valid);

   // Next-state, registered-output and protocol-check logic
   always_comb begin
      state_d  = state;
      grant_d  = grant_q;
      addr_d   = addr_q;
      mreq_d   = mreq_q;
      rr_ptr_d = rr_ptr;
      winner_d = winner;
      count_d  = count;
      err_d    = err_q;

      if (grant_q != '0) begin
         if (bus.mem_valid) begin
            if (count == LEN_CNT) err_d = 1'b1;
            if (count != '1)      count_d = count + CNT_W'(1);
         end
         if (bus.mem_complete && (seen != LEN_CNT1)) err_d = 1'b1;
      end else if (bus.mem_valid || bus.mem_ack || bus.mem_complete) begin
         // nobody owns the port, so any memory response is unexpected
         err_d = 1'b1;
      end

      case (state)
         IDLE: begin
            if (found) begin
               state_d  = REQ;
               grant_d  = NUM_REQ'(1) << pick;
               addr_d   = pick_addr;
               mreq_d   = 1'b1;
               winner_d = pick;
               count_d  = '0;
            end
         end
         REQ: begin
            if (bus.mem_ack) begin
               mreq_d = 1'b0;
               if (bus.mem_complete) begin
                  state_d  = IDLE;
                  grant_d  = '0;
                  rr_ptr_d = rr_next;
               end else begin
                  state_d = BURST;
               end
            end
         end
         BURST: begin
            if (bus.mem_complete) begin
               state_d  = IDLE;
               grant_d  = '0;
               rr_ptr_d = rr_next;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            mreq_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         grant_q <= '0;
         addr_q  <= '0;
         mreq_q  <= 1'b0;
         rr_ptr  <= '0;
         winner  <= '0;
         count   <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         mreq_q  <= mreq_d;
         rr_ptr  <= rr_ptr_d;
         winner  <= winner_d;
         count   <= count_d;
         err_q   <= err_d;
      end
   end

   // Zero-latency response steering to the owner only
   assign bus.req_ack      = grant_q & {NUM_REQ{bus.mem_ack}};
   assign bus.req_valid    = grant_q & {NUM_REQ{bus.mem_valid}};
   assign bus.req_complete = grant_q & {NUM_REQ{bus.mem_complete}};
   assign bus.req_data     = bus.mem_data;
   assign bus.mem_address  = addr_q;
   assign bus.mem_request  = mreq_q;
   assign bus.grant        = grant_q;
   assign bus.burst_error  = err_q;
endmodule

// File: doc/sdram_read_arbiter.md
# sdram_read_arbiter

Shares the single SDRAM burst-read master port between several read-only requesters: the blitter cache, the display fetch and the instruction cache. Each requester presents the same request/ack/valid/complete burst handshake that it would use on a dedicated port, so the requester logic is unchanged. The block does round-robin arbitration, holds the memory request until the memory acknowledges it, and routes the returned burst words back to the granted requester only.

## Interface
- NUM_REQ, 3: number of requesters; index 0 is the blit cache.
- ADDR_W, 26: byte address width.
- BURST_LEN, 8: 32-bit words per burst; the block checks the returned count against this value.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_request  in  NUM_REQ  per-requester burst request; held high until that requester's req_ack.
- req_address  in  NUM_REQ*ADDR_W  per-requester burst base address; slice i belongs to requester i.
- req_ack  out  NUM_REQ  one-hot; the memory accepted the granted request.
- req_valid  out  NUM_REQ  one-hot; a burst data word is present on req_data.
- req_complete  out  NUM_REQ  one-hot; the granted burst has finished.
- req_data  out  32  direct copy of mem_data, shared by all requesters.
- mem_address  out  ADDR_W  registered burst address.
- mem_request  out  1  registered request to the SDRAM controller.
- mem_data  in  32  burst read data.
- mem_valid  in  1  data word valid.
- mem_ack  in  1  request accepted.
- mem_complete  in  1  burst finished.
- grant  out  NUM_REQ  one-hot owner of the port; all zero when idle.
- burst_error  out  1  sticky protocol-error flag.

## Operation
- States:
  - IDLE: grant = 0, mem_request = 0.
  - REQ: mem_request = 1 while waiting for mem_ack.
  - BURST: waiting for mem_complete.
- IDLE with any req_request high:
  - Pick the winner by round-robin. The search starts at rr_ptr and wraps modulo NUM_REQ.
  - Register grant = onehot(winner), mem_address = that requester's address slice, mem_request = 1.
  - Next state REQ.
- REQ:
  - mem_ack clears mem_request at the same edge and moves the state to BURST.
  - If mem_ack and mem_complete arrive in the same cycle, go straight to IDLE.
- BURST: mem_complete moves the state to IDLE, sets rr_ptr = (winner+1) mod NUM_REQ and clears grant.
- Response routing is combinational:
  - req_ack = grant & {NUM_REQ{mem_ack}}.
  - req_valid = grant & {NUM_REQ{mem_valid}}.
  - req_complete = grant & {NUM_REQ{mem_complete}}.
  - mem_valid and mem_ack may occur in the same cycle; both are forwarded.
- Word counter:
  - 4-bit counter, cleared on every grant, incremented on each mem_valid while grant is non-zero. It does not saturate below 15.
  - burst_error is set if mem_valid arrives when the count already equals BURST_LEN.
  - burst_error is set if mem_complete arrives with count plus the current-cycle valid not equal to BURST_LEN.
  - burst_error is cleared only by reset.
- mem_valid, mem_ack or mem_complete while in IDLE: not forwarded (grant = 0), and burst_error is set.
- A requester that drops req_request after being granted does not cancel the burst. The burst runs to mem_complete and the words are still routed to that requester.
- A requester whose req_request stays high after its complete is treated as a new request and re-arbitrated.
- Reset (asynchronous, any state):
  - State IDLE.
  - mem_request = 0, mem_address = 0, grant = 0.
  - rr_ptr = 0, counter = 0, burst_error = 0.
  - req_ack, req_valid and req_complete are all 0 because grant = 0.
  - Memory responses still in flight after reset follow the IDLE rule above.

## Timing
- Arbitration latency: request seen in IDLE at cycle t gives mem_request = 1 from t+1.
- mem_request stays high through the cycle in which mem_ack is high, and is low from the next cycle.
- Response forwarding adds zero cycles: req_ack, req_valid, req_complete and req_data appear in the same cycle as the memory signals.
- Turnaround: mem_complete at cycle t gives IDLE at t+1 and the next mem_request at t+2 at the earliest.
- There is exactly one IDLE cycle between bursts.
- Worst-case wait for requester i is NUM_REQ-1 full bursts.

## Test plan
- Single requester: only req 1 requests addr 0x0001240; memory acks after 3 cycles and then returns 8 valids -> mem_address 0x0001240; mem_request high for 4 cycles; req_valid only on bit 1 (0b010) for 8 beats; req_complete on bit 1; burst_error 0.
- Simultaneous requests: reqs 0, 1 and 2 all request at once from reset -> grants in order 0, 1, 2, 0 while all three are held; each next mem_request appears exactly 2 cycles after the previous mem_complete.
- Same-cycle events: mem_ack in the same cycle as the first mem_valid, and mem_complete in the same cycle as the eighth valid -> all forwarded; state returns to IDLE; burst_error 0.
- Reset mid-burst: reset asserted after 4 of 8 valids, released, then the remaining 4 valids arrive -> mem_request 0 and grant 0 immediately; stray valids not forwarded; burst_error 1.
- Short burst: mem_complete after 7 valids -> burst_error 1; state IDLE; the next burst is served normally.
- Requester drop: req 2 lowers its request one cycle after grant, before ack -> burst still completes and req_valid bit 2 pulses 8 times.
